// File: rtl/zuss_pkg.sv
`default_nettype none
// ============================================================================
// Module      : zuss_pkg
// Description : Shared ALU op codes, decode->execute entry type and helpers
//               for the ZUSS ID/EX stage.
// Revision    : 1.0 - initial release
// ============================================================================
package zuss_pkg;

    localparam int C_XLEN   = 32;
    localparam int C_RIDX_W = 5;

    localparam logic [3:0] ALU_OP_ADD = 4'b0000;
    localparam logic [3:0] ALU_OP_SUB = 4'b0001;
    localparam logic [3:0] ALU_OP_OR  = 4'b0010;
    localparam logic [3:0] ALU_OP_AND = 4'b0011;

    typedef logic [3:0] alu_op_t;

    typedef struct packed {
        logic [C_XLEN-1:0]   a;
        logic [C_XLEN-1:0]   b;
        alu_op_t             op;
        logic [C_RIDX_W-1:0] rs1;
        logic [C_RIDX_W-1:0] rs2;
        logic [C_RIDX_W-1:0] rd;
    } ex_entry_t;

    // Only the four base ops are legal; everything with op[3:2]!=0 is not.
    function automatic logic op_is_illegal(input alu_op_t op);
        return !(op inside {ALU_OP_ADD, ALU_OP_SUB, ALU_OP_OR, ALU_OP_AND});
    endfunction

endpackage
`default_nettype wire

// File: rtl/zuss_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : zuss_fwd_mux
// Description : Writeback-to-operand forwarding mux. Active only when the
//               ZUSS_FWD_EN macro is defined; otherwise a pass-through.
// Revision    : 1.0 - initial release
// ============================================================================
module zuss_fwd_mux #(
    parameter int XLEN   = 32,
    parameter int RIDX_W = 5
) (
    input  logic [XLEN-1:0]   i_val,
    input  logic [RIDX_W-1:0] i_rs,
    input  logic              i_wb_en,
    input  logic [RIDX_W-1:0] i_wb_rd,
    input  logic [XLEN-1:0]   i_wb_data,
    output logic [XLEN-1:0]   o_val
);

`ifdef ZUSS_FWD_EN
    // Index 0 means immediate or x0, which must never be overwritten.
    assign o_val = (i_wb_en && (i_rs != '0) && (i_wb_rd == i_rs)) ? i_wb_data : i_val;
`else
    logic w_unused;
    assign w_unused = ^{i_rs, i_wb_en, i_wb_rd, i_wb_data};
    assign o_val    = i_val;
`endif

endmodule
`default_nettype wire

// File: rtl/zuss_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : zuss_id_ex_stage
// Description : Decode-to-execute stage with a 2-entry skid buffer, sync flush
//               and optional writeback forwarding (macro ZUSS_FWD_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module zuss_id_ex_stage
    import zuss_pkg::*;
#(
    parameter int XLEN   = C_XLEN,
    parameter int RIDX_W = C_RIDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_a,
    input  logic [XLEN-1:0]   in_b,
    input  logic [3:0]        in_op,
    input  logic [RIDX_W-1:0] in_rs1,
    input  logic [RIDX_W-1:0] in_rs2,
    input  logic [RIDX_W-1:0] in_rd,
    input  logic              wb_en,
    input  logic [RIDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [3:0]        alu_op,
    output logic [RIDX_W-1:0] out_rd,
    output logic              out_illegal
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;

    ex_entry_t r_m;
    ex_entry_t r_s;
    logic      r_m_ill;
    logic      r_s_ill;

    ex_entry_t w_src     [3];
    ex_entry_t w_src_fwd [3];
    logic [XLEN-1:0] w_a_fwd [3];
    logic [XLEN-1:0] w_b_fwd [3];

    logic w_accept;
    logic w_fire;
    logic w_load_m_in;
    logic w_load_m_s;
    logic w_load_s_in;

    assign w_src[0] = '{a: in_a, b: in_b, op: in_op, rs1: in_rs1, rs2: in_rs2, rd: in_rd};
    assign w_src[1] = r_m;
    assign w_src[2] = r_s;

    // Source 0 = incoming decode, 1 = main slot, 2 = skid slot.
    for (genvar g = 0; g < 3; g++) begin : g_src
        zuss_fwd_mux #(.XLEN(XLEN), .RIDX_W(RIDX_W)) u_fwd_a (
            .i_val     (w_src[g].a),
            .i_rs      (w_src[g].rs1),
            .i_wb_en   (wb_en),
            .i_wb_rd   (wb_rd),
            .i_wb_data (wb_data),
            .o_val     (w_a_fwd[g])
        );
        zuss_fwd_mux #(.XLEN(XLEN), .RIDX_W(RIDX_W)) u_fwd_b (
            .i_val     (w_src[g].b),
            .i_rs      (w_src[g].rs2),
            .i_wb_en   (wb_en),
            .i_wb_rd   (wb_rd),
            .i_wb_data (wb_data),
            .o_val     (w_b_fwd[g])
        );
        always_comb begin
            w_src_fwd[g]   = w_src[g];
            w_src_fwd[g].a = w_a_fwd[g];
            w_src_fwd[g].b = w_b_fwd[g];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush wins over any accept in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_accept) w_state_nxt = S_ONE;
                S_ONE: begin
                    if (w_accept && !w_fire)      w_state_nxt = S_FULL;
                    else if (!w_accept && w_fire) w_state_nxt = S_EMPTY;
                end
                S_FULL:  if (w_fire) w_state_nxt = S_ONE;
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // Output / slot-load decode
    always_comb begin
        out_valid   = (r_state != S_EMPTY);
        in_ready    = (r_state != S_FULL);
        w_accept    = in_valid && (r_state != S_FULL);
        w_fire      = out_ready && (r_state != S_EMPTY);
        w_load_m_in = 1'b0;
        w_load_m_s  = 1'b0;
        w_load_s_in = 1'b0;
        if (!flush) begin
            case (r_state)
                S_EMPTY: w_load_m_in = w_accept;
                S_ONE: begin
                    w_load_m_in = w_accept && w_fire;
                    w_load_s_in = w_accept && !w_fire;
                end
                S_FULL:  w_load_m_s = w_fire;
                default: ;
            endcase
        end
    end

    // Slot storage; held valid entries absorb matching writebacks in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m     <= '0;
            r_s     <= '0;
            r_m_ill <= 1'b0;
            r_s_ill <= 1'b0;
        end else begin
            if (w_load_m_in) begin
                r_m     <= w_src_fwd[0];
                r_m_ill <= op_is_illegal(in_op);
            end else if (w_load_m_s) begin
                r_m     <= w_src_fwd[2];
                r_m_ill <= r_s_ill;
            end else if (r_state != S_EMPTY) begin
                r_m     <= w_src_fwd[1];
            end

            if (w_load_s_in) begin
                r_s     <= w_src_fwd[0];
                r_s_ill <= op_is_illegal(in_op);
            end else if (r_state == S_FULL) begin
                r_s     <= w_src_fwd[2];
            end
        end
    end

    assign alu_a       = r_m.a;
    assign alu_b       = r_m.b;
    assign alu_op      = r_m.op;
    assign out_rd      = r_m.rd;
    assign out_illegal = r_m_ill;

endmodule
`default_nettype wire
